uart_rx_fc: RTL and testbench
=============================

Name: uart_rx_fc

Overview:
UART receiver with RTS/CTS hardware flow control. It is the host-facing counterpart of the TDC readout transmitter and is used on the bench and link side to ingest the TX stream. It oversamples the RX line, deframes 8N1 bytes and buffers them in a first-word-fall-through FIFO. It drives rts_n into the peer's CTS input so the transmitter pauses before the FIFO overflows.

Parameters:
CLK_FREQ_HZ, 200_000_000, system clock frequency (5 ns period).
BAUD, 115200, line rate.
OVERSAMPLE, 16, ticks per bit; must be even and at least 8.
FIFO_DEPTH, 16, receive buffer entries; must be a power of 2.
RTS_MARGIN, 4, free entries kept in reserve when rts_n deasserts.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
rx  input  1  serial line, idles high, asynchronous to clk
rts_n  output  1  low = peer may send; connects to peer CTS
m_data  output  8  head-of-FIFO byte
m_valid  output  1  FIFO not empty
m_ready  input  1  consumer accepts m_data
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy
frame_err  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: byte dropped because FIFO full
parity_err  output  1  sticky: parity mismatch (see Optional Feature)
err_clr  input  1  one-cycle pulse clears all sticky flags

Behaviour:
- Reset (async assert, sync release): m_data=0, m_valid=0, fifo_count=0, rts_n=1, all error flags=0, FSM=IDLE, tick counter=0, rx synchroniser=1.
- rx passes through a 2-FF synchroniser, reset value 1. All decisions use the synchronised value rx_s.
- Tick generator: DIV = CLK_FREQ_HZ/(BAUD*OVERSAMPLE), integer division, minimum 1. It is free-running and pulses one cycle every DIV clocks.
- FSM states and transitions:
  - IDLE: rx_s==0 → START; clear the tick count.
  - START: after OVERSAMPLE/2 ticks, sample rx_s. If 1, treat as a glitch → IDLE. If 0 → DATA with bit index 0.
  - DATA: every OVERSAMPLE ticks, sample one bit, LSB first. After bit 7 → STOP, or PARITY when the feature is enabled.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - If 1, push the byte → IDLE, the same cycle. This allows back-to-back frames.
    - If 0, set frame_err, discard the byte → BREAK.
  - BREAK: wait for rx_s==1 → IDLE.
- Push timing: m_valid and m_data update 1 cycle after the stop-sample cycle when the FIFO was empty.
- FIFO behaviour:
  - Pop occurs when m_valid && m_ready.
  - Push with count==FIFO_DEPTH and no pop in the same cycle: byte dropped, overrun set, count unchanged.
  - Push and pop in the same cycle while full: both happen and count stays at FIFO_DEPTH. Same rule when not full: count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- rts_n is registered:
  - 1 when count >= FIFO_DEPTH-RTS_MARGIN, otherwise 0.
  - Updates 1 cycle after the count changes.
  - First goes low on the 2nd clock after reset release.
- Error flags are sticky until err_clr. If err_clr and a new set event occur in the same cycle, set wins.
- rst_n asserted mid-frame aborts the frame immediately; no partial byte is pushed.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: frame is 8E1. A PARITY state samples the 9th bit, OVERSAMPLE ticks after bit 7. Even parity is required: XOR of data and the parity bit must be 0. On mismatch, set parity_err and discard the byte, but still enter STOP and check framing.
- Undefined: frame is 8N1 and parity_err is tied 0.

Test Plan:
- Common setup: CLK_FREQ_HZ=200_000_000, BAUD=1_562_500 (DIV=8, bit=128 clk). Drive rx 0xA5 8N1 with m_ready=1 → exactly one m_valid pulse, m_data=0xA5, frame_err=0, overrun=0.
- Glitch rejection: rx low for 40 clk, then high → no push, fifo_count=0, FSM back in IDLE. A following 0x5A frame is received correctly.
- Framing error: send 0x3C with stop bit held low for 200 clk → frame_err=1, fifo_count=0. err_clr pulse → frame_err=0.
- Flow control and overrun, m_ready=0:
  - After 12 bytes: fifo_count=12 and rts_n=1 on the next cycle.
  - 4 more bytes: count=16.
  - 17th byte: overrun=1, count=16, and head byte is still byte #1.
  - Then m_ready=1 → drains in order, and rts_n=0 once count<12.
- Reset mid-frame: pull rst_n low during DATA bit 3 → all outputs take reset values at once. Release it, then send 0x81 → received as 0x81.
- UART_RX_PARITY_EN defined:
  - 0x01 with parity bit 1 → accepted, parity_err=0.
  - 0x01 with parity bit 0 → parity_err=1, no push.

Source files
------------

// File: rtl/uart_rx_fc.sv
// Purpose : 8N1 UART receiver (8E1 with UART_RX_PARITY_EN) with FWFT receive FIFO and RTS flow control.
// Latency : byte appears on m_data/m_valid 1 clk after the stop-bit sample when the FIFO was empty.
// Backpres: m_ready stalls the FIFO; rts_n rises once occupancy reaches FIFO_DEPTH-RTS_MARGIN; a byte arriving
//           while full is dropped and flagged as overrun.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset (async assert, sync release)
//   rx                  serial line (idle high), asynchronous to clk
//   rts_n               low = peer may transmit (drives peer CTS)
//   m_data/m_valid/m_ready  first-word-fall-through byte stream
//   fifo_count          FIFO occupancy (0..FIFO_DEPTH)
//   frame_err/overrun/parity_err  sticky error flags, cleared by err_clr (a simultaneous set wins)
// Optional: `define UART_RX_PARITY_EN selects 8E1 framing; otherwise 8N1 and parity_err is tied 0.
// Parameter rules: OVERSAMPLE even and >= 8; FIFO_DEPTH a power of 2 and >= 2.

// Small generic synchronous FIFO, first-word-fall-through.
// Latency: a write into an empty FIFO is visible on head_dat the next cycle.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when a slot is freed in the same cycle.
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so the output has a defined reset value
  // without resetting the storage array.
  assign head_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module uart_rx_fc #(
  parameter int CLK_FREQ_HZ = 200_000_000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int RTS_MARGIN  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic                          rts_n,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err,
  input  logic                          err_clr
);
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int DIV_RAW = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW      = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] RTS_THR   = CW'(FIFO_DEPTH - RTS_MARGIN);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  // ---------------------------------------------------------------- rx sync
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------- tick generator
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // --------------------------------------------------------------------- FSM
  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          par_bad;     // parity of the current frame failed; byte is not pushed
  logic          sample_now;

  // START samples mid-bit (half a bit period); every other state a full bit later.
  assign sample_now = tick && (tick_cnt == ((state == S_START) ? HALF_LAST : FULL_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      par_bad  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          tick_cnt <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START, S_DATA, S_PARITY, S_STOP: begin
          if (tick) begin
            if (sample_now) begin
              tick_cnt <= '0;
              case (state)
                S_START: begin
                  if (rx_s) begin
                    state <= S_IDLE;          // start bit did not hold: glitch
                  end else begin
                    state   <= S_DATA;
                    bit_idx <= '0;
                    par_bad <= 1'b0;
                  end
                end
                S_DATA: begin
                  shift   <= {rx_s, shift[7:1]};   // LSB arrives first
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state <= S_PARITY;
`else
                    state <= S_STOP;
`endif
                  end
                end
                S_PARITY: begin
                  par_bad <= (^shift) ^ rx_s;
                  state   <= S_STOP;
                end
                default: begin              // S_STOP
                  state <= rx_s ? S_IDLE : S_BREAK;
                end
              endcase
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Push in the stop-sample cycle itself so the FSM is back in IDLE in time
  // for a start bit that immediately follows the stop bit.
  logic stop_sample;
  logic push_req;
  logic frame_set;
  logic par_set;

  assign stop_sample = (state == S_STOP) && sample_now;
  assign push_req    = stop_sample && rx_s && !par_bad;
  assign frame_set   = stop_sample && !rx_s;
`ifdef UART_RX_PARITY_EN
  assign par_set     = (state == S_PARITY) && sample_now && ((^shift) ^ rx_s);
`else
  assign par_set     = 1'b0;
`endif

  // -------------------------------------------------------------------- FIFO
  logic pop;
  logic fifo_full;
  logic drop;

  assign pop     = m_valid && m_ready;
  assign m_valid = (fifo_count != '0);
  assign drop    = push_req && fifo_full && !pop;

  uart_rx_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_req),
    .push_dat (shift),
    .pop      (pop),
    .head_dat (m_data),
    .count    (fifo_count),
    .full     (fifo_full)
  );

  // -------------------------------------------------------------------- RTS
  // rts_armed holds rts_n high for one extra clock after reset release so the
  // peer is not released before the receiver front end has settled.
  logic rts_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rts_armed <= 1'b0;
      rts_n     <= 1'b1;
    end else begin
      rts_armed <= 1'b1;
      rts_n     <= !rts_armed || (fifo_count >= RTS_THR);
    end
  end

  // ------------------------------------------------------------ sticky flags
  // Set has priority over clear so an event coinciding with err_clr is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_set || (frame_err && !err_clr);
      overrun   <= drop      || (overrun   && !err_clr);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= par_set || (parity_err && !err_clr);
    end
  end
`else
  assign parity_err = par_set;
`endif
endmodule

// File: tb/tb_uart_rx_fc.sv
`timescale 1ns/100ps
module tb_uart_rx_fc;
  localparam int CLK_HZ = 200_000_000;
  localparam int BAUDR  = 1_562_500;
  localparam int OS     = 16;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 4;
  localparam int BIT    = 128;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       m_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic       rts_n;
  logic [7:0] m_data;
  logic       m_valid;
  logic [4:0] fifo_count;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  logic [7:0] exp_q[$];

  always #2.5 clk = ~clk;

  uart_rx_fc #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD        (BAUDR),
    .OVERSAMPLE  (OS),
    .FIFO_DEPTH  (DEPTH),
    .RTS_MARGIN  (MARGIN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rts_n      (rts_n),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .err_clr    (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted byte must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      pops++;
      if (exp_q.size() == 0) check("extra_pop_valid", 32'(m_valid), 32'd0);
      else                   check("pop_data", 32'(m_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] good(input logic [7:0] d);
    return {^d, d};
  endfunction

  task automatic send_frame(input logic [8:0] bits, input logic stop, input int stop_len);
    rx = 1'b0;
    cyc(BIT);
    for (int i = 0; i < NB; i++) begin
      rx = bits[i];
      cyc(BIT);
    end
    rx = stop;
    cyc(stop_len);
    rx = 1'b1;
  endtask

  task automatic wait_count(input logic [4:0] target, input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (fifo_count != target && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(fifo_count), 32'(target));
  endtask

  int p0;
  logic [7:0] d;

  initial begin
    // ---- reset values
    cyc(5);
    @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_rts_n", 32'(rts_n), 1);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_parity_err", 32'(parity_err), 0);
    cyc(1);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rts_edge1_high", 32'(rts_n), 1);
    @(negedge clk);
    check("rts_edge2_low", 32'(rts_n), 0);

    // ---- basic 0xA5 frame
    cyc(1);
    m_ready = 1'b1;
    p0 = pops;
    exp_q.push_back(8'hA5);
    send_frame(good(8'hA5), 1'b1, BIT);
    cyc(20);
    check("a5_one_pop", 32'(pops - p0), 1);
    check("a5_frame_err", 32'(frame_err), 0);
    check("a5_overrun", 32'(overrun), 0);

    // ---- glitch rejection then 0x5A
    p0 = pops;
    rx = 1'b0;
    cyc(40);
    rx = 1'b1;
    cyc(100);
    check("glitch_count", 32'(fifo_count), 0);
    check("glitch_no_pop", 32'(pops - p0), 0);
    exp_q.push_back(8'h5A);
    send_frame(good(8'h5A), 1'b1, BIT);
    cyc(20);
    check("after_glitch_pop", 32'(pops - p0), 1);

    // ---- framing error
    p0 = pops;
    send_frame(good(8'h3C), 1'b0, 200);
    cyc(20);
    check("ferr_set", 32'(frame_err), 1);
    check("ferr_count", 32'(fifo_count), 0);
    check("ferr_no_pop", 32'(pops - p0), 0);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    @(negedge clk);
    check("ferr_cleared", 32'(frame_err), 0);

    // ---- flow control and overrun
    cyc(1);
    m_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      d = 8'h10 + 8'(i);
      if (i < 16) exp_q.push_back(d);
      send_frame(good(d), 1'b1, BIT);
      if (i == 11) begin
        @(negedge clk);
        check("flow_cnt12", 32'(fifo_count), 12);
        @(negedge clk);
        check("flow_rts12", 32'(rts_n), 1);
      end
      if (i == 15) begin
        @(negedge clk);
        check("flow_cnt16", 32'(fifo_count), 16);
        check("flow_no_overrun", 32'(overrun), 0);
      end
    end
    cyc(2);
    @(negedge clk);
    check("ovr_set", 32'(overrun), 1);
    check("ovr_count", 32'(fifo_count), 16);
    check("ovr_head", 32'(m_data), 32'h10);
    cyc(1);
    m_ready = 1'b1;
    wait_count(5'd11, "drain_cnt11");
    check("drain_rts_hold", 32'(rts_n), 1);
    @(negedge clk);
    check("drain_rts_low", 32'(rts_n), 0);
    wait_count(5'd0, "drain_empty");
    cyc(4);
    check("drain_q_empty", 32'(exp_q.size()), 0);

    // ---- reset mid-frame (overrun still set, one byte held)
    m_ready = 1'b0;
    send_frame(good(8'h11), 1'b1, BIT);
    cyc(4);
    @(negedge clk);
    check("pre_rst_count", 32'(fifo_count), 1);
    check("pre_rst_overrun", 32'(overrun), 1);
    cyc(1);
    d = 8'hC6;
    rx = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      cyc(BIT);
    end
    rx = d[3];
    cyc(BIT/2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_valid", 32'(m_valid), 0);
    check("mid_rst_m_data", 32'(m_data), 0);
    check("mid_rst_count", 32'(fifo_count), 0);
    check("mid_rst_rts_n", 32'(rts_n), 1);
    check("mid_rst_overrun", 32'(overrun), 0);
    rx = 1'b1;
    cyc(4);
    rst_n = 1'b1;
    cyc(4);
    m_ready = 1'b1;
    p0 = pops;
    exp_q.push_back(8'h81);
    send_frame(good(8'h81), 1'b1, BIT);
    cyc(20);
    check("post_rst_pop", 32'(pops - p0), 1);

`ifdef UART_RX_PARITY_EN
    // ---- even parity
    p0 = pops;
    exp_q.push_back(8'h01);
    send_frame({1'b1, 8'h01}, 1'b1, BIT);
    cyc(20);
    check("par_ok_pop", 32'(pops - p0), 1);
    check("par_ok_flag", 32'(parity_err), 0);
    p0 = pops;
    send_frame({1'b0, 8'h01}, 1'b1, BIT);
    cyc(20);
    check("par_bad_flag", 32'(parity_err), 1);
    check("par_bad_no_pop", 32'(pops - p0), 0);
    check("par_bad_count", 32'(fifo_count), 0);
    check("par_bad_frame", 32'(frame_err), 0);
`endif

    check("final_q_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
